// File: rtl/mem_stage.sv
// MEMORY stage: data-memory req/gnt/rvalid sequencing, byte-lane steering, load extension
// and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid_M,
    input  logic [DATA_WIDTH-1:0] i_alu_result_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4_M,
    input  logic [DATA_WIDTH-1:0] i_pc_target_M,
    input  logic [REG_WIDTH-1:0]  i_rd_M,
    input  logic                  i_reg_write_M,
    input  logic [1:0]            i_result_src_M,
    input  logic                  i_mem_write_M,
    input  logic [2:0]            i_funct3_M,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [DATA_WIDTH-1:0] o_dmem_addr,
    output logic [3:0]            o_dmem_be,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic                  i_dmem_gnt,
    input  logic                  i_dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                  o_stall_M,
    output logic                  o_misaligned_M,
    output logic [DATA_WIDTH-1:0] o_result_W,
    output logic [REG_WIDTH-1:0]  o_rd_W,
    output logic                  o_reg_write_W
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [REG_WIDTH-1:0]  rd_q;
    logic                  reg_write_q;

    logic                  is_store, is_load, is_access;
    logic                  misaligned, aligned_access;
    logic                  stall;
    logic [1:0]            offset;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] load_data;

    // A store wins if the upstream ever flags both; result_src alone marks a load.
    assign is_store  = i_valid_M & i_mem_write_M;
    assign is_load   = i_valid_M & (i_result_src_M == 2'b01) & ~i_mem_write_M;
    assign is_access = is_store | is_load;
    assign offset    = i_alu_result_M[1:0];

    always_comb begin
        misaligned = 1'b0;
        if (is_access) begin
            if (i_funct3_M[1]) begin
                misaligned = (offset != 2'b00);
            end else if (i_funct3_M[0]) begin
                misaligned = offset[0];
            end
        end
    end

    assign aligned_access = is_access & ~misaligned;
    assign o_misaligned_M = misaligned;

    // Request fields come straight from the held upstream inputs, so they stay stable in StReq.
    assign o_dmem_req  = (state_q == StIdle) ? aligned_access : (state_q == StReq);
    assign o_dmem_we   = o_dmem_req & is_store;
    assign o_dmem_addr = {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        if (i_funct3_M[1]) begin
            o_dmem_be    = 4'b1111;
            o_dmem_wdata = i_write_data_M;
        end else if (i_funct3_M[0]) begin
            o_dmem_be    = 4'b0011 << offset;
            o_dmem_wdata = {2{i_write_data_M[15:0]}};
        end else begin
            o_dmem_be    = 4'b0001 << offset;
            o_dmem_wdata = {4{i_write_data_M[7:0]}};
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            StIdle: begin
                stall = aligned_access & ~(i_dmem_gnt & is_store);
                if (aligned_access) begin
                    if (!i_dmem_gnt) begin
                        state_d = StReq;
                    end else if (is_load) begin
                        state_d = StResp;
                    end
                end
            end
            StReq: begin
                stall = ~(i_dmem_gnt & is_store);
                if (i_dmem_gnt) begin
                    state_d = is_load ? StResp : StIdle;
                end
            end
            StResp: begin
                stall = ~i_dmem_rvalid;
                if (i_dmem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                stall   = 1'b0;
            end
        endcase
    end

    assign o_stall_M = stall;

    assign rdata_shift = i_dmem_rdata >> {offset, 3'b000};

    always_comb begin
        if (i_funct3_M[1]) begin
            load_data = i_dmem_rdata;
        end else if (i_funct3_M[0]) begin
            load_data = {{16{rdata_shift[15] & ~i_funct3_M[2]}}, rdata_shift[15:0]};
        end else begin
            load_data = {{24{rdata_shift[7] & ~i_funct3_M[2]}}, rdata_shift[7:0]};
        end
    end

    always_comb begin
        unique case (i_result_src_M)
            2'b00: result_d = i_alu_result_M;
            2'b01: result_d = load_data;
            2'b10: result_d = i_pc_plus4_M;
            2'b11: result_d = i_pc_target_M;
            default: result_d = i_alu_result_M;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                result_q    <= result_d;
                rd_q        <= i_rd_M;
                reg_write_q <= i_reg_write_M & i_valid_M & ~misaligned;
            end else begin
                reg_write_q <= 1'b0;
            end
        end
    end

    assign o_result_W    = result_q;
    assign o_rd_W        = rd_q;
    assign o_reg_write_W = reg_write_q;

endmodule
